// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding, word width and parity helpers.
// Imported by the transmitter, its baud generator and the receive side.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 10417;
    localparam logic        PARITY_SENSE_EVEN    = 1'b0;
    localparam logic        PARITY_SENSE_ODD     = 1'b1;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps, and flags the last cycle.
// clr holds the count at 0 so the first bit after clr is a full period.
module uart_baud_gen
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with a one-word holding buffer; frame format set by
// PARITY_EN / PARITY_ODD / STOP_BITS.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx
);

    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic       ODD       = (PARITY_ODD != 0);

    state_t     state;
    logic       hold_valid;
    logic [7:0] hold_data;
    logic [7:0] shift;
    logic [2:0] bit_idx;
    logic       parity_bit;
    logic       tick;

    // Counter is held at 0 while idle; every other state change happens on its wrap.
    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == S_IDLE),
        .tick (tick)
    );

    assign tx_ready = ~hold_valid;
    assign tx_done  = (state == S_STOP) && tick && (bit_idx == LAST_STOP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            shift      <= '0;
            bit_idx    <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
        end else begin
            if (tx_start && !hold_valid) begin
                hold_valid <= 1'b1;
                hold_data  <= tx_data;
            end
            case (state)
                S_IDLE: begin
                    if (hold_valid) begin
                        state      <= S_START;
                        shift      <= hold_data;
                        parity_bit <= parity_of(hold_data, ODD);
                        hold_valid <= 1'b0;
                        tx         <= 1'b0;
                        tx_busy    <= 1'b1;
                    end
                end
                S_START: begin
                    if (tick) begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                        tx      <= shift[0];
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                state <= S_PARITY;
                                tx    <= parity_bit;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        state <= S_STOP;
                        tx    <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (bit_idx == LAST_STOP) begin
                            bit_idx <= '0;
                            // A queued word starts immediately, with no idle cycle.
                            if (hold_valid) begin
                                state      <= S_START;
                                shift      <= hold_data;
                                parity_bit <= parity_of(hold_data, ODD);
                                hold_valid <= 1'b0;
                                tx         <= 1'b0;
                            end else begin
                                state   <= S_IDLE;
                                tx      <= 1'b1;
                                tx_busy <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
